// File: rtl/or1_uart_pkg.sv
// Shared UART definitions: state encoding, data/frame sizes.
// Optional macro UART_TX_PARITY_EN adds the parity state and one frame bit.
package or1_uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PAR   = 3'd4,
`endif
        S_STOP  = 3'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake bundle between a producer and the UART transmitter.
// Ports: d (byte), valid (producer holds d), ready (consumer accepts).
interface uart_tx_if;
    logic [7:0] d;
    logic       valid;
    logic       ready;

    modport master (output d, output valid, input ready);
    modport slave  (input d, input valid, output ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Ports: clk, rst_n, restart (force count to 0), bit_end (last cycle of bit).
module uart_baud_cnt #(
    parameter int CLKDIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);

    localparam int W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLKDIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign bit_end = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (restart || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames (8E1 with UART_TX_PARITY_EN), LSB first.
// Ports: clk, rst_n, up (byte handshake, slave), txd (serial out), busy.
module uart_tx
    import or1_uart_pkg::*;
#(
    parameter int CLKDIV = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave up,
    output logic     txd,
    output logic     busy
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       txd_q, txd_d;
    logic       init_q;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    logic hs;
    logic bit_end;
    logic restart;

    uart_baud_cnt #(.CLKDIV(CLKDIV)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .bit_end (bit_end)
    );

    // init_q keeps ready low until the first edge after reset release.
    assign up.ready = init_q
                    & ((state_q == S_IDLE)
                    | ((state_q == S_STOP) & bit_end));
    assign hs      = up.valid & up.ready;
    assign restart = hs | (state_q == S_IDLE);
    assign txd     = txd_q;
    assign busy    = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PAR: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (hs) begin
            state_d = S_START;
            shift_d = up.d;
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^up.d;
`endif
        end

        // Line level follows the next state so txd comes straight off a flop.
        txd_d = 1'b1;
        unique case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PAR:   txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
            init_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            init_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, frames, back-to-back, mid-frame reset.
// Define UART_TX_PARITY_EN to run the parity build at CLKDIV=2.
module tb_uart_tx;
    import or1_uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int CLKDIV = 2;
`else
    localparam int CLKDIV = 4;
`endif
    localparam int FL = FRAME_BITS * CLKDIV;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic txd;
    logic busy;

    uart_tx_if bus();

    uart_tx #(.CLKDIV(CLKDIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (bus),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame bits LSB first: start, data, parity-or-stop, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b,
                                             input logic p);
`ifdef UART_TX_PARITY_EN
        return {1'b1, p, b, 1'b0};
`else
        return {1'b1, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic wait_ready();
        for (int n = 0; n < 64 && !bus.ready; n++) tick();
        check("wait_ready", {31'd0, bus.ready}, 32'd1);
    endtask

    // Starts in the cycle after the handshake edge; ends one cycle past
    // the frame. poke >= 0 pulses valid with d=FF at that cycle.
    task automatic run_frame(input string tag,
                             input logic [10:0] exp,
                             input int poke);
        for (int i = 0; i < FL; i++) begin
            if (poke >= 0 && i == poke) begin
                bus.d = 8'hFF;
                bus.valid = 1'b1;
            end else if (poke >= 0 && i == poke + 1) begin
                bus.valid = 1'b0;
            end
            check({tag, "_txd"}, {31'd0, txd}, {31'd0, exp[i / CLKDIV]});
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_rdy"}, {31'd0, bus.ready},
                  (i == FL - 1) ? 32'd1 : 32'd0);
            tick();
        end
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready();
        bus.d = b;
        bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_txd"}, {31'd0, txd}, 32'd1);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_rdy"}, {31'd0, bus.ready}, 32'd1);
    endtask

    initial begin
        bus.d = 8'h00;
        bus.valid = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdy", {31'd0, bus.ready}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("rel");
        for (int i = 0; i < 100; i++) begin
            check("quiet_txd", {31'd0, txd}, 32'd1);
            check("quiet_busy", {31'd0, busy}, 32'd0);
            tick();
        end

        send(8'hA5);
        run_frame("a5", frame_of(8'hA5, 1'b0), -1);
        check_idle("a5");

        // Back-to-back: valid stays high, second byte taken in last stop cycle.
        wait_ready();
        bus.d = 8'h00;
        bus.valid = 1'b1;
        tick();
        bus.d = 8'hFF;
        run_frame("b2b0", frame_of(8'h00, 1'b0), -1);
        bus.valid = 1'b0;
        run_frame("b2b1", frame_of(8'hFF, 1'b0), -1);
        check_idle("b2b");

        send(8'h3C);
        run_frame("3c", frame_of(8'h3C, 1'b0), 3 * CLKDIV + 1);
        check_idle("3c");

        // Reset while bit 3 of 0x55 (a 0) is on the line.
        send(8'h55);
        repeat (4 * CLKDIV + 1) tick();
        check("mid_txd_pre", {31'd0, txd}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_txd", {31'd0, txd}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rdy", {31'd0, bus.ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("mid_rel");
        send(8'h55);
        run_frame("55", frame_of(8'h55, 1'b0), -1);
        check_idle("55");

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        run_frame("p07", frame_of(8'h07, 1'b1), -1);
        check_idle("p07");
        send(8'h03);
        run_frame("p03", frame_of(8'h03, 1'b0), -1);
        check_idle("p03");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKDIV, default 16, CLK cycles per serial bit; legal range 2..256.
REQ-002 CLK  input  1  single clock; all flops update on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 D  input  8  byte to transmit; sampled only at handshake.
REQ-005 VALID  input  1  upstream holds D valid.
REQ-006 READY  output  1  block accepts D this cycle.
REQ-007 TXD  output  1  serial line; idle high.
REQ-008 BUSY  output  1  high while a frame is on TXD.

Function
REQ-009 Handshake SHALL occur on a rising CLK edge with VALID=1 and READY=1; D latched into the shift register at that edge.
REQ-010 VALID while READY=0 SHALL be ignored, with D not sampled and no state change.
REQ-011 States SHALL be IDLE, START, DATA, PAR (PARITY_EN only), STOP.
REQ-012 IDLE: TXD=1, BUSY=0, READY=1; handshake -> START.
REQ-013 Start bit TXD=0 SHALL begin in the cycle after the handshake edge.
REQ-014 START lasts CLKDIV cycles, then -> DATA.
REQ-015 DATA SHALL send 8 bits LSB first, each CLKDIV cycles, then -> PAR or STOP.
REQ-016 STOP: TXD=1 for CLKDIV cycles.
REQ-017 READY SHALL also be 1 in the final STOP cycle; handshake there -> START with no idle gap.
REQ-018 STOP end without handshake -> IDLE.
REQ-019 Frame length SHALL be 10*CLKDIV cycles (11*CLKDIV with parity).
REQ-020 BUSY SHALL be 1 in START/DATA/PAR/STOP.
REQ-021 Bit counter width SHALL be ceil(log2(CLKDIV)); it wraps to 0 at CLKDIV-1.
REQ-022 Data index counter SHALL be 3 bits, 0..7, with no wrap beyond 7.
REQ-023 TXD SHALL be driven from a flop, with no combinational glitch path.

Reset
REQ-024 RST_N=0 SHALL asynchronously force TXD=1, BUSY=0, READY=0, state IDLE, and all counters 0.
REQ-025 READY SHALL rise in the first cycle after RST_N deasserts.
REQ-026 Reset mid-frame SHALL discard the frame, with TXD immediately high and no partial retransmit.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, a PAR state of CLKDIV cycles carrying even parity (XOR of the 8 data bits) SHALL sit between DATA and STOP.
REQ-028 Without UART_TX_PARITY_EN, there SHALL be no PAR state and no parity logic, and DATA goes directly to STOP.

Structure
REQ-029 Shared package or1_uart_pkg SHALL hold the state enum, DATA_BITS=8, and FRAME_BITS (10, or 11 with parity).
REQ-030 Sub-module uart_baud_cnt SHALL hold a CLKDIV-cycle counter with restart input and bit_end pulse output.
REQ-031 It SHALL be reused by the future uart_rx.

Verification
REQ-032 Reset release, CLKDIV=4, VALID=0 -> TXD=1, BUSY=0, READY=1 from cycle 1; TXD stays 1 for 100 cycles.
REQ-033 CLKDIV=4, D=8'hA5 handshake at edge k -> TXD: 0 during k+1..k+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop 1; READY=1 at k+40.
REQ-034 CLKDIV=4, VALID held high, D=8'h00 then 8'hFF -> second start bit begins the cycle after the first stop's last cycle; no idle gap.
REQ-035 D=8'h3C handshake, D changed to 8'hFF and VALID pulsed mid-frame -> transmitted bits still 0x3C; second VALID ignored.
REQ-036 RST_N pulsed low at bit 3 of D=8'h55 -> TXD=1 within the reset pulse, BUSY=0; after release, the next handshake sends a clean full frame.
REQ-037 UART_TX_PARITY_EN, CLKDIV=2, D=8'h07 -> parity bit 1 after bit 7; frame length 22 cycles; D=8'h03 -> parity bit 0.
